// File: rtl/mrr_decode_stream_arbiter.sv
// Packet-level round-robin arbiter merging per-pathway decode streams onto one AXI-stream.
// Each beat is tagged with its source pathway; a pathway stalling mid-packet is aborted.
`timescale 1ns/1ps
module mrr_decode_stream_arbiter #(
  parameter int                    NUM_PATHWAYS  = 4,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ID_WIDTH      = 2,
  parameter int                    TIMEOUT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] ABORT_WORD    = 32'hDEAD0000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH*NUM_PATHWAYS-1:0] i_tdata,
  input  logic [NUM_PATHWAYS-1:0]            i_tvalid,
  input  logic [NUM_PATHWAYS-1:0]            i_tlast,
  output logic [NUM_PATHWAYS-1:0]            i_tready,
  output logic [DATA_WIDTH-1:0]              o_tdata,
  output logic [ID_WIDTH-1:0]                o_tuser,
  output logic                               o_tlast,
  output logic                               o_tvalid,
  input  logic                               o_tready,
  input  logic [TIMEOUT_WIDTH-1:0]           pkt_timeout,
  output logic                               grant_valid,
  output logic [ID_WIDTH-1:0]                grant_id,
  output logic [15:0]                        abort_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_ABORT  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic [DATA_WIDTH-1:0]    r_tdata;
  logic [ID_WIDTH-1:0]      r_tuser;
  logic                     r_tlast;
  logic                     r_tvalid;
  logic                     r_grant_valid;
  logic [ID_WIDTH-1:0]      r_grant_id;
  logic [ID_WIDTH-1:0]      r_last_grant;
  logic [15:0]              r_abort_count;
  logic [TIMEOUT_WIDTH-1:0] r_stall_cnt;

  logic [DATA_WIDTH-1:0]    w_lane_data [NUM_PATHWAYS];
  logic [DATA_WIDTH-1:0]    w_sel_data;
  logic                     w_sel_valid;
  logic                     w_sel_last;
  logic                     w_out_free;
  logic                     w_accept;
  logic                     w_timeout;
  logic                     w_abort_load;
  logic                     w_pick_found;
  logic [ID_WIDTH-1:0]      w_pick_id;

  generate
    for (genvar gi = 0; gi < NUM_PATHWAYS; gi++) begin : g_lane
      assign w_lane_data[gi] = i_tdata[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH];
    end
  endgenerate

  assign w_sel_data   = w_lane_data[r_grant_id];
  assign w_sel_valid  = i_tvalid[r_grant_id];
  assign w_sel_last   = i_tlast[r_grant_id];
  assign w_out_free   = !r_tvalid || o_tready;
  assign w_accept     = (r_state == ST_STREAM) && w_sel_valid && w_out_free;
  // A beat arriving on the timeout cycle wins, so only a still-idle source aborts.
  assign w_timeout    = (r_state == ST_STREAM) && !w_sel_valid &&
                        (pkt_timeout != '0) && (r_stall_cnt == pkt_timeout);
  assign w_abort_load = (r_state == ST_ABORT) && w_out_free;

  // Round-robin search starting just after the last granted pathway; the
  // descending loop lets the nearest valid candidate overwrite farther ones.
  always_comb begin
    int idx;
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    idx          = 0;
    for (int off = NUM_PATHWAYS; off >= 1; off--) begin
      idx = (int'(r_last_grant) + off) % NUM_PATHWAYS;
      if (i_tvalid[idx]) begin
        w_pick_found = 1'b1;
        w_pick_id    = ID_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    i_tready     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        i_tready[r_grant_id] = w_out_free;
        if (w_accept && w_sel_last) begin
          w_state_next = ST_IDLE;
        end else if (w_timeout) begin
          w_state_next = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (w_out_free) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output register: a new load takes priority over draining the held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (w_accept) begin
      r_tdata  <= w_sel_data;
      r_tuser  <= r_grant_id;
      r_tlast  <= w_sel_last;
      r_tvalid <= 1'b1;
    end else if (w_abort_load) begin
      r_tdata  <= ABORT_WORD;
      r_tuser  <= r_grant_id;
      r_tlast  <= 1'b1;
      r_tvalid <= 1'b1;
    end else if (o_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_last_grant  <= ID_WIDTH'(NUM_PATHWAYS - 1);
      r_abort_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_grant_id    <= w_pick_id;
            r_grant_valid <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_accept && w_sel_last) begin
            r_last_grant  <= r_grant_id;
            r_grant_valid <= 1'b0;
          end
        end
        ST_ABORT: begin
          if (w_out_free) begin
            r_last_grant  <= r_grant_id;
            r_grant_valid <= 1'b0;
            if (r_abort_count != 16'hFFFF) begin
              r_abort_count <= r_abort_count + 16'd1;
            end
          end
        end
        default: r_grant_valid <= 1'b0;
      endcase
    end
  end

  // Held at zero outside STREAM so every new grant starts a fresh stall window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state != ST_STREAM) || w_accept) begin
      r_stall_cnt <= '0;
    end else if (!w_sel_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_tdata     = r_tdata;
  assign o_tuser     = r_tuser;
  assign o_tlast     = r_tlast;
  assign o_tvalid    = r_tvalid;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign abort_count = r_abort_count;

endmodule
